regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL expose parameter NUM_READ, default 2, number of independent read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 readAddr  input  NUM_READ*ADDR_WIDTH  packed read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 dout  output  NUM_READ*DATA_WIDTH  packed read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 readBusy  output  NUM_READ  per-port flag: addressed register has an outstanding producer.
REQ-009 write  input  1  writeback strobe.
REQ-010 writeAddr  input  ADDR_WIDTH  writeback destination index.
REQ-011 din  input  DATA_WIDTH  writeback data.
REQ-012 issue  input  1  strobe: an instruction producing a result has been issued.
REQ-013 issueAddr  input  ADDR_WIDTH  destination index of the issued instruction.
REQ-014 pendCount  output  ADDR_WIDTH+1  number of registers currently marked pending.

Function
REQ-015 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits plus one pending bit per register.
REQ-016 Register 0 SHALL read as zero on every port; writes and issues targeting index 0 SHALL be ignored; pend[0] SHALL stay 0.
REQ-017 On a rising edge with write=1 and writeAddr!=0, mem[writeAddr] SHALL take din; visible in the register array the following cycle.
REQ-018 Reads SHALL be combinational: dout port i = mem[readAddr i], zero-cycle latency, all ports independent, identical addresses allowed.
REQ-019 On a rising edge with issue=1 and issueAddr!=0, pend[issueAddr] SHALL be set to 1.
REQ-020 On a rising edge with write=1 and writeAddr!=0, pend[writeAddr] SHALL be cleared to 0 unless REQ-021 applies.
REQ-021 Simultaneous issue and write to the same nonzero index: pend SHALL end at 1 (new producer wins) and mem SHALL take din.
REQ-022 Issue to an already-pending index SHALL leave it pending (no nesting count); a single later write clears it.
REQ-023 Write to a non-pending index SHALL update mem and leave pend at 0.
REQ-024 readBusy port i SHALL equal pend[readAddr i], subject to REQ-032.
REQ-025 pendCount SHALL be a registered population count of pend, updated on the same edge as pend; range 0..2**ADDR_WIDTH-1.
REQ-026 Simultaneous issue and write to different indices SHALL both take effect in the same cycle (pendCount net change 0).

Reset
REQ-027 reset=1 at a rising edge SHALL clear every mem entry to 0, every pend bit to 0, and pendCount to 0.
REQ-028 reset SHALL dominate write and issue asserted in the same cycle; neither takes effect.
REQ-029 While reset is held, dout SHALL read 0 on all ports and readBusy SHALL be 0 from the first reset edge onward.
REQ-030 Reset asserted mid-operation with pending registers SHALL discard all pending state; no writeback after reset is required.

Configuration
REQ-031 Macro REGFILE_SB_BYPASS_EN SHALL select write-to-read forwarding.
REQ-032 Defined: when write=1, writeAddr!=0 and readAddr i==writeAddr, dout port i SHALL be din combinationally, and readBusy port i SHALL be 0 unless issue=1 with issueAddr==writeAddr in the same cycle.
REQ-033 Undefined: no forwarding; dout and readBusy SHALL reflect registered state only, so a same-cycle write is visible one cycle later.

Verification
REQ-034 Reset, then read indices 0..31 on all ports -> every dout 0, readBusy 0, pendCount 0.
REQ-035 write index 5 = 0xDEADBEEF, next cycle readAddr0=5, readAddr1=5 -> both ports 0xDEADBEEF; write index 0 = 0xFFFFFFFF -> index 0 still reads 0.
REQ-036 issue 7, issue 9, then readAddr0=7 -> readBusy0=1, pendCount=2; write 7 = 0x12 -> pendCount=1, readBusy0=0, dout0=0x12.
REQ-037 Same cycle issue 3 and write 3 = 0xAA -> next cycle pend[3]=1, mem[3]=0xAA, pendCount unchanged+1 if previously clear.
REQ-038 With REGFILE_SB_BYPASS_EN: write 4 = 0x55 while readAddr0=4 -> dout0=0x55 same cycle; without macro -> old value same cycle, 0x55 next cycle.
REQ-039 Issue 10, 11, 12, then reset with write 10 = 0x1 in same cycle -> after edge mem[10]=0, pendCount=0, all readBusy 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a pending (scoreboard) bit per register and a registered pending count.
// Optional write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] dout,
  output logic [NUM_READ-1:0]            readBusy,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          writeAddr,
  input  logic [DATA_WIDTH-1:0]          din,
  input  logic                           issue,
  input  logic [ADDR_WIDTH-1:0]          issueAddr,
  output logic [ADDR_WIDTH:0]            pendCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
  localparam logic [DEPTH-1:0]      ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      pend_r;
  logic [DEPTH-1:0]      pend_nxt_s;
  logic [DEPTH-1:0]      wr_dec_s;
  logic [DEPTH-1:0]      iss_dec_s;
  logic [ADDR_WIDTH:0]   pend_cnt_r;
  logic                  wr_en_s;
  logic                  iss_en_s;
  logic [ADDR_WIDTH-1:0] raddr_s [NUM_READ];

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = {(ADDR_WIDTH+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      c = c + {{ADDR_WIDTH{1'b0}}, v[k]};
    end
    return c;
  endfunction

  assign wr_en_s   = write && (writeAddr != ZERO_ADDR);
  assign iss_en_s  = issue && (issueAddr != ZERO_ADDR);
  assign wr_dec_s  = {{(DEPTH-1){1'b0}}, wr_en_s} << writeAddr;
  assign iss_dec_s = {{(DEPTH-1){1'b0}}, iss_en_s} << issueAddr;
  // Issue is applied after the writeback clear so a new producer on the same index wins.
  assign pend_nxt_s = ((pend_r & ~wr_dec_s) | iss_dec_s) & ~ONE_HOT0;
  assign pendCount  = pend_cnt_r;

  // State update: register storage, pending bits and their population count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= ZERO_DATA;
      end
      pend_r     <= {DEPTH{1'b0}};
      pend_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[writeAddr] <= din;
      end
      pend_r     <= pend_nxt_s;
      pend_cnt_r <= popcount(pend_nxt_s);
    end
  end

  // Combinational read ports with register 0 hardwired to zero
  always_comb begin
    dout     = {(NUM_READ*DATA_WIDTH){1'b0}};
    readBusy = {NUM_READ{1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin
      raddr_s[i] = readAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (reset || (raddr_s[i] == ZERO_ADDR)) begin
        dout[i*DATA_WIDTH +: DATA_WIDTH] = ZERO_DATA;
        readBusy[i]                      = 1'b0;
      end
`ifdef REGFILE_SB_BYPASS_EN
      else if (wr_en_s && (raddr_s[i] == writeAddr)) begin
        dout[i*DATA_WIDTH +: DATA_WIDTH] = din;
        readBusy[i]                      = iss_en_s && (issueAddr == writeAddr);
      end
`endif
      else begin
        dout[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[raddr_s[i]];
        readBusy[i]                      = pend_r[raddr_s[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  logic [NR*AW-1:0] readAddr;
  logic [NR*DW-1:0] dout;
  logic [NR-1:0] readBusy;
  logic write;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] din;
  logic issue;
  logic [AW-1:0] issueAddr;
  logic [AW:0] pendCount;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit m_pend [DEPTH];

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
    .clk(clk), .reset(reset), .readAddr(readAddr), .dout(dout), .readBusy(readBusy),
    .write(write), .writeAddr(writeAddr), .din(din), .issue(issue), .issueAddr(issueAddr),
    .pendCount(pendCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [AW:0] m_count();
    logic [AW:0] c = '0;
    for (int k = 0; k < DEPTH; k++) c = c + (AW+1)'(m_pend[k]);
    return c;
  endfunction

  function automatic logic [AW-1:0] rd(int p);
    return readAddr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_dout(int p);
    logic [AW-1:0] a = rd(p);
    if (reset || a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (write && writeAddr != 0 && a == writeAddr) return din;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int p);
    logic [AW-1:0] a = rd(p);
    if (reset || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (write && writeAddr != 0 && a == writeAddr) return issue && (issueAddr == writeAddr);
`endif
    return m_pend[a];
  endfunction

  // Advance one clock and apply the register-file rules to the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[k] = '0;
        m_pend[k] = 1'b0;
      end
    end else begin
      if (write && writeAddr != 0) begin
        m_mem[writeAddr] = din;
        m_pend[writeAddr] = 1'b0;
      end
      if (issue && issueAddr != 0) m_pend[issueAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    write = 1'b0;
    issue = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b1; writeAddr = 5'd3; din = 32'hCAFE0001;
    issue = 1'b1; issueAddr = 5'd3; readAddr = {5'd3, 5'd3};
    tick();
    tick();
    @(negedge clk);
    for (int p = 0; p < NR; p++) begin
      n_checks++;
      if (dout[p*DW +: DW] !== 32'h0 || readBusy[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold port%0d: dout=%h busy=%b expected 0/0", p, dout[p*DW +: DW], readBusy[p]);
      end
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      readAddr = {AW'(a), AW'(a)};
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        n_checks++;
        if (dout[p*DW +: DW] !== 32'h0 || readBusy[p] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read idx%0d port%0d: dout=%h busy=%b expected 0/0", a, p, dout[p*DW +: DW], readBusy[p]);
        end
      end
    end
    n_checks++;
    if (pendCount !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_pendcount: got %0d expected 0", pendCount);
    end
    tick();
  endtask

  task automatic test_write_read();
    write = 1'b1; writeAddr = 5'd5; din = 32'hDEADBEEF;
    tick();
    idle();
    readAddr = {5'd5, 5'd5};
    @(negedge clk);
    for (int p = 0; p < NR; p++) begin
      n_checks++;
      if (dout[p*DW +: DW] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL write5 port%0d: got %h expected deadbeef", p, dout[p*DW +: DW]);
      end
    end
    write = 1'b1; writeAddr = 5'd0; din = 32'hFFFFFFFF; issue = 1'b1; issueAddr = 5'd0;
    tick();
    idle();
    readAddr = {5'd0, 5'd5};
    @(negedge clk);
    n_checks++;
    if (dout[DW +: DW] !== 32'h0 || readBusy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reg0_write: dout=%h busy=%b expected 0/0", dout[DW +: DW], readBusy[1]);
    end
    n_checks++;
    if (dout[0 +: DW] !== 32'hDEADBEEF || pendCount !== 6'd0) begin
      n_fail++;
      $display("FAIL reg0_indep: dout0=%h cnt=%0d expected deadbeef/0", dout[0 +: DW], pendCount);
    end
    tick();
  endtask

  task automatic test_pending();
    issue = 1'b1; issueAddr = 5'd7;
    tick();
    issueAddr = 5'd9;
    tick();
    idle();
    readAddr = {5'd9, 5'd7};
    @(negedge clk);
    n_checks++;
    if (readBusy !== 2'b11 || pendCount !== 6'd2) begin
      n_fail++;
      $display("FAIL issue_7_9: busy=%b cnt=%0d expected 11/2", readBusy, pendCount);
    end
    write = 1'b1; writeAddr = 5'd7; din = 32'h12;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (pendCount !== 6'd1 || readBusy !== 2'b10 || dout[0 +: DW] !== 32'h12) begin
      n_fail++;
      $display("FAIL wb7: cnt=%0d busy=%b dout0=%h expected 1/10/12", pendCount, readBusy, dout[0 +: DW]);
    end
    issue = 1'b1; issueAddr = 5'd9;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (pendCount !== 6'd1 || readBusy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reissue9: cnt=%0d busy1=%b expected 1/1", pendCount, readBusy[1]);
    end
    write = 1'b1; writeAddr = 5'd9; din = 32'h99;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (pendCount !== 6'd0 || readBusy[1] !== 1'b0 || dout[DW +: DW] !== 32'h99) begin
      n_fail++;
      $display("FAIL wb9: cnt=%0d busy1=%b dout1=%h expected 0/0/99", pendCount, readBusy[1], dout[DW +: DW]);
    end
    tick();
  endtask

  task automatic test_same_index();
    issue = 1'b1; issueAddr = 5'd3; write = 1'b1; writeAddr = 5'd3; din = 32'hAA;
    tick();
    idle();
    readAddr = {5'd3, 5'd3};
    @(negedge clk);
    n_checks++;
    if (readBusy[0] !== 1'b1 || dout[0 +: DW] !== 32'hAA || pendCount !== 6'd1) begin
      n_fail++;
      $display("FAIL same_idx3: busy=%b dout=%h cnt=%0d expected 1/aa/1", readBusy[0], dout[0 +: DW], pendCount);
    end
    issue = 1'b1; issueAddr = 5'd8; write = 1'b1; writeAddr = 5'd3; din = 32'hBB;
    tick();
    idle();
    readAddr = {5'd8, 5'd3};
    @(negedge clk);
    n_checks++;
    if (readBusy !== 2'b10 || dout[0 +: DW] !== 32'hBB || pendCount !== 6'd1) begin
      n_fail++;
      $display("FAIL diff_idx: busy=%b dout0=%h cnt=%0d expected 10/bb/1", readBusy, dout[0 +: DW], pendCount);
    end
    tick();
  endtask

  task automatic test_bypass();
    write = 1'b1; writeAddr = 5'd4; din = 32'h11;
    tick();
    readAddr = {5'd0, 5'd4}; write = 1'b1; writeAddr = 5'd4; din = 32'h55;
    @(negedge clk);
    n_checks++;
`ifdef REGFILE_SB_BYPASS_EN
    if (dout[0 +: DW] !== 32'h55 || readBusy[0] !== 1'b0) begin
`else
    if (dout[0 +: DW] !== 32'h11 || readBusy[0] !== 1'b0) begin
`endif
      n_fail++;
      $display("FAIL bypass_same_cycle: dout0=%h busy0=%b", dout[0 +: DW], readBusy[0]);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (dout[0 +: DW] !== 32'h55) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: got %h expected 55", dout[0 +: DW]);
    end
    issue = 1'b1; issueAddr = 5'd4;
    tick();
    idle();
    write = 1'b1; writeAddr = 5'd4; din = 32'h66;
    @(negedge clk);
    n_checks++;
`ifdef REGFILE_SB_BYPASS_EN
    if (readBusy[0] !== 1'b0 || dout[0 +: DW] !== 32'h66) begin
`else
    if (readBusy[0] !== 1'b1 || dout[0 +: DW] !== 32'h55) begin
`endif
      n_fail++;
      $display("FAIL bypass_busy: busy0=%b dout0=%h", readBusy[0], dout[0 +: DW]);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int a = 10; a <= 12; a++) begin
      issue = 1'b1; issueAddr = AW'(a);
      tick();
    end
    idle();
    readAddr = {5'd11, 5'd10};
    @(negedge clk);
    n_checks++;
    if (readBusy !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_pending: busy=%b expected 11", readBusy);
    end
    reset = 1'b1; write = 1'b1; writeAddr = 5'd10; din = 32'h1;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (dout[0 +: DW] !== 32'h0 || readBusy !== 2'b00 || pendCount !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset: dout0=%h busy=%b cnt=%0d expected 0/00/0", dout[0 +: DW], readBusy, pendCount);
    end
    readAddr = {5'd0, 5'd12};
    @(negedge clk);
    n_checks++;
    if (readBusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset12: busy0=%b expected 0", readBusy[0]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] ra [NR];
    logic [AW:0] exp_cnt;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      write = $urandom_range(0, 1) == 1;
      writeAddr = AW'($urandom_range(0, 15));
      din = $urandom;
      issue = $urandom_range(0, 1) == 1;
      issueAddr = ($urandom_range(0, 3) == 0) ? writeAddr : AW'($urandom_range(0, 15));
      for (int p = 0; p < NR; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? writeAddr : AW'($urandom_range(0, 15));
      readAddr = {ra[1], ra[0]};
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        n_checks++;
        if (dout[p*DW +: DW] !== exp_dout(p) || readBusy[p] !== exp_busy(p)) begin
          n_fail++;
          $display("FAIL rand%0d port%0d idx%0d: dout=%h busy=%b expected %h/%b",
                   n, p, rd(p), dout[p*DW +: DW], readBusy[p], exp_dout(p), exp_busy(p));
        end
      end
      exp_cnt = m_count();
      n_checks++;
      if (pendCount !== exp_cnt) begin
        n_fail++;
        $display("FAIL rand%0d pendcount: got %0d expected %0d", n, pendCount, exp_cnt);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; issue = 1'b0;
    writeAddr = '0; issueAddr = '0; din = '0; readAddr = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k] = '0;
      m_pend[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_pending();
    test_same_index();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
